border_stats_engine: RTL and testbench
======================================

Name: border_stats_engine

Overview:
Parametrised successor of the per-frame border analyser. It accumulates background-pixel statistics (min, max, sum, count) per side (TOP/BOTTOM/LEFT/RIGHT) and per level along hardware-sprite tile borders. At each frame boundary it snapshots the accumulators into a shadow bank and computes means with a sequential divider. Query logic returns min/max/mean/count and an in-range ("between") test. It sits between the sprite descriptor pipeline and the VPU collision/blend logic.

Parameters:
NUM_CH, 4, number of hardware sprite descriptor channels
NUM_LEVELS, 32, number of levels per side (power of 2)
TILE, 16, tile edge in pixels (power of 2); border offsets are 0 and TILE-1
PIXEL_W, 24, background pixel width, compared and summed as an unsigned word
COUNT_W, 16, per-entry counter width; SUM_W = PIXEL_W+COUNT_W (local)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
new_frame  in  1  one-cycle frame-start pulse
new_pixel  in  1  bg_pixel/h_in valid strobe
bg_pixel  in  PIXEL_W  current background pixel
h_in  in  NUM_CH*HW  descriptors, HW=LW+9+2*OW+1, LW=clog2(NUM_LEVELS), OW=clog2(TILE); per channel {level[LW], id[9], off_x[OW], off_y[OW], is_border}
side_select  in  2  00=TOP 01=BOTTOM 10=LEFT 11=RIGHT
level_select  in  LW  queried level
query_pixel  in  PIXEL_W  pixel for the between test
min_selected / max_selected / media_selected  out  PIXEL_W  shadow-bank stats of the selected entry
count_selected  out  COUNT_W  shadow-bank count
entry_valid  out  1  selected entry count != 0
between  out  1  entry_valid && min<=query_pixel<=max
results_valid  out  1  shadow bank complete (all means computed)
busy  out  1  divider running
overrun  out  1  sticky; new_frame arrived while busy

Behaviour:
- Reset: all accumulators and the shadow bank are cleared. All outputs are 0. FSM goes to IDLE.
- Hit rule: channel c hits when new_pixel, id!=0 and is_border. It contributes to TOP if off_y==0, BOTTOM if off_y==TILE-1, LEFT if off_x==0, RIGHT if off_x==TILE-1. A corner pixel hits two sides.
- Merging: for each (side, level), k = number of channels hitting it this cycle (0..NUM_CH).
  - count += k, sum += k*bg_pixel.
  - min/max are updated once with bg_pixel when k>0. The first hit (count==0) loads min=max=bg_pixel, so a black pixel is a valid value.
  - Multiple hits are never lost (no last-write-wins).
- Saturation: count saturates at 2^COUNT_W-1 and sum at 2^SUM_W-1. Once count saturates, sum stops updating.
- new_frame: in the same cycle, the accumulators are copied to the shadow bank, the accumulators are cleared, and results_valid goes to 0.
  - A new_pixel coincident with new_frame is accumulated into the NEW frame; the snapshot excludes it.
  - If busy at new_frame: the snapshot is skipped, overrun is set (sticky until reset), the accumulators are still cleared, and the divider continues on the old shadow data.
- Divider FSM, entries e = 0..4*NUM_LEVELS-1 (side-major):
  - IDLE -> LOAD on snapshot.
  - LOAD (1 cycle): latch sum/count of entry e.
  - DIV (SUM_W cycles): restoring shift-subtract.
  - STORE (1 cycle): mean (low PIXEL_W bits of the quotient; 0 if count==0) written to the shadow bank; e+1 -> LOAD, last entry -> DONE.
  - DONE (1 cycle): results_valid=1, then -> IDLE.
  - busy=1 in LOAD/DIV/STORE.
  - Total latency from new_frame to results_valid = 4*NUM_LEVELS*(SUM_W+2)+1 cycles (5377 at defaults).
- Query: outputs are registered with 1-cycle latency from side_select/level_select/query_pixel. They read the shadow bank; media_selected is valid only when results_valid.
- Reset mid-divide: immediate return to IDLE with everything cleared; overrun is cleared.

Test Plan:
- Ch0 {level=3, id=1, off_x=5, off_y=0, border}; pixels 0x10, 0x20, 0x30, 0x40; new_frame; wait 5377 cycles -> TOP/3: min 0x10, max 0x40, count 4, mean 0x28, results_valid=1; query 0x25 -> between=1; query 0x41 -> between=0.
- Corner off_x=0, off_y=0, level 7, pixel 0x000000 -> TOP/7 and LEFT/7 both count 1, min=max=mean=0, entry_valid=1; BOTTOM/7 entry_valid=0.
- Ch0 and ch2 both hit BOTTOM/1 (off_y=15) with pixel 100 in one cycle -> count 2, sum 200, mean 100; a descriptor with id=0 or is_border=0 is ignored.
- Second new_frame 100 cycles after the first -> overrun=1; the first frame's results complete; accumulators are cleared; the pixel coincident with that new_frame is counted in the new frame.
- Assert rst_n=0 during DIV -> next cycle busy=0, results_valid=0, all selected outputs 0, overrun=0.
- 65536 hits of 0xFFFFFF on one entry -> count saturates at 0xFFFF; mean 0xFFFFFF.

Source files
------------

// File: rtl/border_stats_engine.sv
// Per-frame border statistics: accumulates min/max/sum/count of background pixels per
// tile-border side and level, snapshots them at frame start and computes means sequentially.
module border_stats_engine #(
    parameter int  NUM_CH     = 4,
    parameter int  NUM_LEVELS = 32,
    parameter int  TILE       = 16,
    parameter int  PIXEL_W    = 24,
    parameter int  COUNT_W    = 16,
    localparam int LW         = $clog2(NUM_LEVELS),
    localparam int OW         = $clog2(TILE),
    localparam int HW         = LW + 9 + 2 * OW + 1,
    localparam int SUM_W      = PIXEL_W + COUNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 new_frame,
    input  logic                 new_pixel,
    input  logic [PIXEL_W-1:0]   bg_pixel,
    input  logic [NUM_CH*HW-1:0] h_in,
    input  logic [1:0]           side_select,
    input  logic [LW-1:0]        level_select,
    input  logic [PIXEL_W-1:0]   query_pixel,
    output logic [PIXEL_W-1:0]   min_selected,
    output logic [PIXEL_W-1:0]   max_selected,
    output logic [PIXEL_W-1:0]   media_selected,
    output logic [COUNT_W-1:0]   count_selected,
    output logic                 entry_valid,
    output logic                 between,
    output logic                 results_valid,
    output logic                 busy,
    output logic                 overrun
);

    localparam int NE = 4 * NUM_LEVELS;
    localparam int EW = $clog2(NE);
    localparam int KW = $clog2(NUM_CH + 1);
    localparam int BW = $clog2(SUM_W);
    localparam logic [COUNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0] SIDE_TOP = 2'd0;
    localparam logic [1:0] SIDE_BOT = 2'd1;
    localparam logic [1:0] SIDE_LFT = 2'd2;
    localparam logic [1:0] SIDE_RGT = 2'd3;

    typedef struct packed {
        logic [PIXEL_W-1:0] mn;
        logic [PIXEL_W-1:0] mx;
        logic [SUM_W-1:0]   sum;
        logic [COUNT_W-1:0] cnt;
    } acc_t;

    localparam acc_t ACC_ZERO = '0;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_STORE, S_DONE} state_t;

    function automatic logic [COUNT_W-1:0] sat_cnt(input logic [COUNT_W:0] v);
        return v[COUNT_W] ? CNT_MAX : v[COUNT_W-1:0];
    endfunction

    function automatic logic [SUM_W-1:0] sat_sum(input logic [SUM_W:0] v);
        return v[SUM_W] ? {SUM_W{1'b1}} : v[SUM_W-1:0];
    endfunction

    // k simultaneous hits on one entry: min/max see the pixel once, count/sum see it k times.
    function automatic acc_t acc_update(input acc_t cur, input logic [KW-1:0] k,
                                        input logic [PIXEL_W-1:0] pix);
        acc_t nxt;
        nxt = cur;
        if (k != '0) begin
            if (cur.cnt == '0) begin
                nxt.mn = pix;
                nxt.mx = pix;
            end else begin
                if (pix < cur.mn) nxt.mn = pix;
                if (pix > cur.mx) nxt.mx = pix;
            end
            if (cur.cnt != CNT_MAX) begin
                nxt.cnt = sat_cnt({1'b0, cur.cnt} + (COUNT_W + 1)'(k));
                nxt.sum = sat_sum({1'b0, cur.sum} + (SUM_W + 1)'(k) * (SUM_W + 1)'(pix));
            end
        end
        return nxt;
    endfunction

    logic [NUM_CH-1:0][LW-1:0] ch_lvl;
    logic [NUM_CH-1:0][OW-1:0] ch_ox;
    logic [NUM_CH-1:0][OW-1:0] ch_oy;
    logic [NUM_CH-1:0]         ch_hit;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [HW-1:0] desc;
        assign desc      = h_in[c*HW +: HW];
        assign ch_lvl[c] = desc[HW-1 -: LW];
        assign ch_ox[c]  = desc[2*OW -: OW];
        assign ch_oy[c]  = desc[OW -: OW];
        assign ch_hit[c] = new_pixel && (desc[2*OW+9 -: 9] != 9'd0) && desc[0];
    end

    logic [KW-1:0] hit_k [NE];
    acc_t          acc_d [NE];
    acc_t          acc_q [NE];

    always_comb begin
        for (int e = 0; e < NE; e++) hit_k[e] = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_hit[c]) begin
                if (ch_oy[c] == '0)
                    hit_k[{SIDE_TOP, ch_lvl[c]}] = hit_k[{SIDE_TOP, ch_lvl[c]}] + KW'(1);
                if (ch_oy[c] == OW'(TILE - 1))
                    hit_k[{SIDE_BOT, ch_lvl[c]}] = hit_k[{SIDE_BOT, ch_lvl[c]}] + KW'(1);
                if (ch_ox[c] == '0)
                    hit_k[{SIDE_LFT, ch_lvl[c]}] = hit_k[{SIDE_LFT, ch_lvl[c]}] + KW'(1);
                if (ch_ox[c] == OW'(TILE - 1))
                    hit_k[{SIDE_RGT, ch_lvl[c]}] = hit_k[{SIDE_RGT, ch_lvl[c]}] + KW'(1);
            end
        end
    end

    // A pixel coincident with new_frame lands on the freshly cleared accumulators.
    always_comb begin
        for (int e = 0; e < NE; e++)
            acc_d[e] = acc_update(new_frame ? ACC_ZERO : acc_q[e], hit_k[e], bg_pixel);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < NE; e++) acc_q[e] <= ACC_ZERO;
        end else begin
            for (int e = 0; e < NE; e++) acc_q[e] <= acc_d[e];
        end
    end

    state_t             state_q;
    logic [EW-1:0]      ent_q;
    logic [BW-1:0]      bit_q;
    logic [SUM_W-1:0]   quo_q;
    logic [COUNT_W-1:0] rem_q;
    logic [COUNT_W-1:0] dvs_q;
    logic               busy_q;
    logic               rv_q;
    logic               overrun_q;
    acc_t               shd_q      [NE];
    logic [PIXEL_W-1:0] shd_mean_q [NE];
    logic               snap;
    logic [COUNT_W:0]   trial;
    logic               trial_ge;

    assign snap     = new_frame && !busy_q;
    assign trial    = {rem_q, quo_q[SUM_W-1]};
    assign trial_ge = trial >= {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ent_q     <= '0;
            bit_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            busy_q    <= 1'b0;
            rv_q      <= 1'b0;
            overrun_q <= 1'b0;
            for (int e = 0; e < NE; e++) begin
                shd_q[e]      <= ACC_ZERO;
                shd_mean_q[e] <= '0;
            end
        end else begin
            if (new_frame && busy_q) overrun_q <= 1'b1;
            unique case (state_q)
                S_IDLE: ;
                S_LOAD: begin
                    quo_q   <= shd_q[ent_q].sum;
                    dvs_q   <= shd_q[ent_q].cnt;
                    rem_q   <= '0;
                    bit_q   <= '0;
                    state_q <= S_DIV;
                end
                S_DIV: begin
                    quo_q <= {quo_q[SUM_W-2:0], trial_ge};
                    rem_q <= trial_ge ? COUNT_W'(trial - {1'b0, dvs_q}) : COUNT_W'(trial);
                    bit_q <= bit_q + BW'(1);
                    if (bit_q == BW'(SUM_W - 1)) state_q <= S_STORE;
                end
                S_STORE: begin
                    shd_mean_q[ent_q] <= (dvs_q == '0) ? '0 : quo_q[PIXEL_W-1:0];
                    if (ent_q == EW'(NE - 1)) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                    end else begin
                        ent_q   <= ent_q + EW'(1);
                        state_q <= S_LOAD;
                    end
                end
                S_DONE: begin
                    rv_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // Snapshot only happens from IDLE/DONE, so it safely overrides the case above.
            if (snap) begin
                state_q <= S_LOAD;
                ent_q   <= '0;
                busy_q  <= 1'b1;
                rv_q    <= 1'b0;
                for (int e = 0; e < NE; e++) begin
                    shd_q[e]      <= acc_q[e];
                    shd_mean_q[e] <= '0;
                end
            end
        end
    end

    logic [EW-1:0]      sel;
    logic [PIXEL_W-1:0] min_sel_d, min_sel_q;
    logic [PIXEL_W-1:0] max_sel_d, max_sel_q;
    logic [PIXEL_W-1:0] mean_sel_d, mean_sel_q;
    logic [COUNT_W-1:0] cnt_sel_d, cnt_sel_q;
    logic               valid_d, valid_q;
    logic               between_d, between_q;

    always_comb begin
        sel        = {side_select, level_select};
        min_sel_d  = shd_q[sel].mn;
        max_sel_d  = shd_q[sel].mx;
        cnt_sel_d  = shd_q[sel].cnt;
        mean_sel_d = shd_mean_q[sel];
        valid_d    = shd_q[sel].cnt != '0;
        between_d  = valid_d && (shd_q[sel].mn <= query_pixel) && (query_pixel <= shd_q[sel].mx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            min_sel_q  <= '0;
            max_sel_q  <= '0;
            mean_sel_q <= '0;
            cnt_sel_q  <= '0;
            valid_q    <= 1'b0;
            between_q  <= 1'b0;
        end else begin
            min_sel_q  <= min_sel_d;
            max_sel_q  <= max_sel_d;
            mean_sel_q <= mean_sel_d;
            cnt_sel_q  <= cnt_sel_d;
            valid_q    <= valid_d;
            between_q  <= between_d;
        end
    end

    assign min_selected   = min_sel_q;
    assign max_selected   = max_sel_q;
    assign media_selected = mean_sel_q;
    assign count_selected = cnt_sel_q;
    assign entry_valid    = valid_q;
    assign between        = between_q;
    assign results_valid  = rv_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_border_stats_engine.sv
// Bench for border_stats_engine: table-driven queries through a scoreboard queue, plus
// hand-written frame, overrun, reset and saturation sequences.
module tb_border_stats_engine;

    localparam int NUM_CH     = 4;
    localparam int NUM_LEVELS = 32;
    localparam int TILE       = 16;
    localparam int PIXEL_W    = 24;
    localparam int COUNT_W    = 16;
    localparam int LW         = 5;
    localparam int OW         = 4;
    localparam int HW         = 23;
    localparam int LATENCY    = 5377;

    typedef struct packed {
        logic [1:0]         side;
        logic [LW-1:0]      lvl;
        logic [PIXEL_W-1:0] qp;
        logic [PIXEL_W-1:0] mn;
        logic [PIXEL_W-1:0] mx;
        logic [PIXEL_W-1:0] mean;
        logic [COUNT_W-1:0] cnt;
        logic               ev;
        logic               bt;
    } qvec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 new_frame;
    logic                 new_pixel;
    logic [PIXEL_W-1:0]   bg_pixel;
    logic [NUM_CH*HW-1:0] h_in;
    logic [1:0]           side_select;
    logic [LW-1:0]        level_select;
    logic [PIXEL_W-1:0]   query_pixel;
    logic [PIXEL_W-1:0]   min_selected;
    logic [PIXEL_W-1:0]   max_selected;
    logic [PIXEL_W-1:0]   media_selected;
    logic [COUNT_W-1:0]   count_selected;
    logic                 entry_valid;
    logic                 between;
    logic                 results_valid;
    logic                 busy;
    logic                 overrun;

    int    total = 0;
    int    bad   = 0;
    qvec_t vecs[16];
    qvec_t sb[$];

    always #5 clk = ~clk;

    border_stats_engine #(
        .NUM_CH(NUM_CH), .NUM_LEVELS(NUM_LEVELS), .TILE(TILE),
        .PIXEL_W(PIXEL_W), .COUNT_W(COUNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .new_frame(new_frame), .new_pixel(new_pixel),
        .bg_pixel(bg_pixel), .h_in(h_in), .side_select(side_select),
        .level_select(level_select), .query_pixel(query_pixel),
        .min_selected(min_selected), .max_selected(max_selected),
        .media_selected(media_selected), .count_selected(count_selected),
        .entry_valid(entry_valid), .between(between), .results_valid(results_valid),
        .busy(busy), .overrun(overrun)
    );

    function automatic logic [HW-1:0] dsc(input logic [LW-1:0] lvl, input logic [8:0] id,
                                          input logic [OW-1:0] ox, input logic [OW-1:0] oy,
                                          input logic b);
        return {lvl, id, ox, oy, b};
    endfunction

    function automatic qvec_t mkv(input logic [1:0] side, input logic [LW-1:0] lvl,
                                  input logic [PIXEL_W-1:0] qp, input logic [PIXEL_W-1:0] mn,
                                  input logic [PIXEL_W-1:0] mx, input logic [PIXEL_W-1:0] mean,
                                  input logic [COUNT_W-1:0] cnt, input logic ev, input logic bt);
        return '{side, lvl, qp, mn, mx, mean, cnt, ev, bt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic px(input logic [NUM_CH*HW-1:0] h, input logic [PIXEL_W-1:0] p);
        h_in      = h;
        bg_pixel  = p;
        new_pixel = 1'b1;
        tick();
        new_pixel = 1'b0;
        h_in      = '0;
    endtask

    task automatic frame();
        new_frame = 1'b1;
        tick();
        new_frame = 1'b0;
    endtask

    task automatic wait_rv(input string name, input int budget);
        int n;
        n = 0;
        while (!results_valid && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(results_valid), 64'(1));
    endtask

    task automatic run_queries(input int lo, input int hi);
        qvec_t e;
        for (int i = lo; i <= hi; i++) begin
            side_select  = vecs[i].side;
            level_select = vecs[i].lvl;
            query_pixel  = vecs[i].qp;
            sb.push_back(vecs[i]);
            tick();
            e = sb.pop_front();
            chk($sformatf("v%0d_min", i),     64'(min_selected),   64'(e.mn));
            chk($sformatf("v%0d_max", i),     64'(max_selected),   64'(e.mx));
            chk($sformatf("v%0d_mean", i),    64'(media_selected), 64'(e.mean));
            chk($sformatf("v%0d_count", i),   64'(count_selected), 64'(e.cnt));
            chk($sformatf("v%0d_valid", i),   64'(entry_valid),    64'(e.ev));
            chk($sformatf("v%0d_between", i), 64'(between),        64'(e.bt));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [(3*HW)-1:0] z3;
        logic [HW-1:0]     d_sat;
        z3 = '0;

        // side 0=TOP 1=BOTTOM 2=LEFT 3=RIGHT
        vecs[0]  = mkv(2'd0, 5'd3, 24'h25, 24'h10, 24'h40, 24'h28, 16'd4, 1'b1, 1'b1);
        vecs[1]  = mkv(2'd0, 5'd3, 24'h41, 24'h10, 24'h40, 24'h28, 16'd4, 1'b1, 1'b0);
        vecs[2]  = mkv(2'd0, 5'd3, 24'h10, 24'h10, 24'h40, 24'h28, 16'd4, 1'b1, 1'b1);
        vecs[3]  = mkv(2'd0, 5'd3, 24'h40, 24'h10, 24'h40, 24'h28, 16'd4, 1'b1, 1'b1);
        vecs[4]  = mkv(2'd0, 5'd3, 24'h0F, 24'h10, 24'h40, 24'h28, 16'd4, 1'b1, 1'b0);
        vecs[5]  = mkv(2'd0, 5'd7, 24'h00, 24'h00, 24'h00, 24'h00, 16'd1, 1'b1, 1'b1);
        vecs[6]  = mkv(2'd2, 5'd7, 24'h00, 24'h00, 24'h00, 24'h00, 16'd1, 1'b1, 1'b1);
        vecs[7]  = mkv(2'd1, 5'd7, 24'h00, 24'h00, 24'h00, 24'h00, 16'd0, 1'b0, 1'b0);
        vecs[8]  = mkv(2'd1, 5'd1, 24'd100, 24'd100, 24'd100, 24'd100, 16'd2, 1'b1, 1'b1);
        vecs[9]  = mkv(2'd3, 5'd3, 24'h00, 24'h00, 24'h00, 24'h00, 16'd0, 1'b0, 1'b0);
        vecs[10] = mkv(2'd3, 5'd2, 24'h111111, 24'h111111, 24'h111111, 24'h111111, 16'd1, 1'b1, 1'b1);
        vecs[11] = mkv(2'd0, 5'd3, 24'h25, 24'h00, 24'h00, 24'h00, 16'd0, 1'b0, 1'b0);
        vecs[12] = mkv(2'd3, 5'd2, 24'h222222, 24'h222222, 24'h222222, 24'h222222, 16'd1, 1'b1, 1'b1);
        vecs[13] = mkv(2'd3, 5'd2, 24'h333333, 24'h222222, 24'h222222, 24'h222222, 16'd1, 1'b1, 1'b0);
        vecs[14] = mkv(2'd2, 5'd9, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 16'hFFFF, 1'b1, 1'b1);
        vecs[15] = mkv(2'd2, 5'd9, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 16'hFFFF, 1'b1, 1'b0);

        rst_n = 1'b0; new_frame = 1'b0; new_pixel = 1'b0; bg_pixel = '0; h_in = '0;
        side_select = 2'd0; level_select = 5'd3; query_pixel = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_min", 64'(min_selected), 64'(0));
        chk("rst_max", 64'(max_selected), 64'(0));
        chk("rst_mean", 64'(media_selected), 64'(0));
        chk("rst_count", 64'(count_selected), 64'(0));
        chk("rst_valid", 64'(entry_valid), 64'(0));
        chk("rst_between", 64'(between), 64'(0));
        chk("rst_results_valid", 64'(results_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_overrun", 64'(overrun), 64'(0));

        // Frame A: TOP/3 run, a black corner, a two-channel merge and ignored descriptors.
        px({z3, dsc(5'd3, 9'd1, 4'd5, 4'd0, 1'b1)}, 24'h10);
        px({z3, dsc(5'd3, 9'd1, 4'd5, 4'd0, 1'b1)}, 24'h20);
        px({z3, dsc(5'd3, 9'd1, 4'd5, 4'd0, 1'b1)}, 24'h30);
        px({z3, dsc(5'd3, 9'd1, 4'd5, 4'd0, 1'b1)}, 24'h40);
        px({z3, dsc(5'd7, 9'd1, 4'd0, 4'd0, 1'b1)}, 24'h00);
        px({dsc(5'd1, 9'd2, 4'd5, 4'd15, 1'b0), dsc(5'd1, 9'd3, 4'd9, 4'd15, 1'b1),
            dsc(5'd1, 9'd0, 4'd5, 4'd15, 1'b1), dsc(5'd1, 9'd1, 4'd5, 4'd15, 1'b1)}, 24'd100);
        h_in = {z3, dsc(5'd3, 9'd1, 4'd5, 4'd0, 1'b1)};
        bg_pixel = 24'h01;
        tick();
        h_in = '0;
        frame();
        chk("a_busy_after_frame", 64'(busy), 64'(1));
        repeat (LATENCY - 1) tick();
        chk("a_rv_before_latency", 64'(results_valid), 64'(0));
        chk("a_busy_done", 64'(busy), 64'(0));
        tick();
        chk("a_rv_at_latency", 64'(results_valid), 64'(1));
        run_queries(0, 9);

        // Overrun: second new_frame while the divider is still running.
        px({z3, dsc(5'd2, 9'd5, 4'd15, 4'd3, 1'b1)}, 24'h111111);
        frame();
        chk("b_overrun_clear", 64'(overrun), 64'(0));
        repeat (50) tick();
        px({z3, dsc(5'd2, 9'd5, 4'd15, 4'd3, 1'b1)}, 24'h333333);
        repeat (48) tick();
        new_frame = 1'b1;
        px({z3, dsc(5'd2, 9'd5, 4'd15, 4'd3, 1'b1)}, 24'h222222);
        new_frame = 1'b0;
        chk("b_overrun_set", 64'(overrun), 64'(1));
        chk("b_busy_continues", 64'(busy), 64'(1));
        chk("b_rv_low", 64'(results_valid), 64'(0));
        wait_rv("b_rv_wait", 6000);
        run_queries(10, 11);
        chk("b_overrun_sticky", 64'(overrun), 64'(1));
        frame();
        chk("c_rv_cleared", 64'(results_valid), 64'(0));
        wait_rv("c_rv_wait", 6000);
        run_queries(12, 13);

        // Reset in the middle of a divide.
        px({z3, dsc(5'd2, 9'd5, 4'd15, 4'd3, 1'b1)}, 24'h444444);
        side_select = 2'd3; level_select = 5'd2; query_pixel = 24'h444444;
        frame();
        repeat (10) tick();
        chk("d_pre_count", 64'(count_selected), 64'(1));
        chk("d_pre_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        tick();
        chk("d_busy", 64'(busy), 64'(0));
        chk("d_rv", 64'(results_valid), 64'(0));
        chk("d_overrun", 64'(overrun), 64'(0));
        chk("d_min", 64'(min_selected), 64'(0));
        chk("d_max", 64'(max_selected), 64'(0));
        chk("d_mean", 64'(media_selected), 64'(0));
        chk("d_count", 64'(count_selected), 64'(0));
        chk("d_valid", 64'(entry_valid), 64'(0));
        chk("d_between", 64'(between), 64'(0));
        rst_n = 1'b1;
        tick();
        chk("d_shadow_cleared", 64'(count_selected), 64'(0));

        // Saturation on LEFT/9: 4 hits/cycle up to 65532, then single hits past 0xFFFF.
        d_sat = dsc(5'd9, 9'd1, 4'd0, 4'd5, 1'b1);
        h_in = {4{d_sat}};
        bg_pixel = 24'hFFFFFF;
        new_pixel = 1'b1;
        repeat (16383) tick();
        h_in = {z3, d_sat};
        repeat (4) tick();
        new_pixel = 1'b0;
        h_in = '0;
        frame();
        wait_rv("e_rv_wait", 6000);
        run_queries(14, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
